// File: rtl/urna_pkg.sv
// Shared types and constants for the vote entry block: FSM states, candidate
// codes, candidate BCD values and the seven-segment digit table.
package urna_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_OFFER, ST_RELEASE} vote_state_e;

   localparam logic [2:0] CAND_12   = 3'd0;
   localparam logic [2:0] CAND_13   = 3'd1;
   localparam logic [2:0] CAND_17   = 3'd2;
   localparam logic [2:0] CAND_51   = 3'd3;
   localparam logic [2:0] CAND_NULL = 3'd4;

   localparam logic [7:0] BCD_12 = 8'h12;
   localparam logic [7:0] BCD_13 = 8'h13;
   localparam logic [7:0] BCD_17 = 8'h17;
   localparam logic [7:0] BCD_51 = 8'h51;

   // Active-low segments, bit order g..a, entry N drives digit N.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [6:0] seg7(input logic [3:0] bcd);
      return (bcd <= 4'd9) ? SEG_TABLE[bcd] : SEG_OFF;
   endfunction

   function automatic logic [2:0] cand_of(input logic [3:0] tens, input logic [3:0] units);
      case ({tens, units})
         BCD_12:  return CAND_12;
         BCD_13:  return CAND_13;
         BCD_17:  return CAND_17;
         BCD_51:  return CAND_51;
         default: return CAND_NULL;
      endcase
   endfunction

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-count debouncer and a
// one-cycle press pulse on the debounced high-to-low edge.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         press <= 1'b0;
         // Any sample matching the accepted level restarts the stability run.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync[1];
            cnt   <= '0;
            press <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vote_entry.sv
// Two-digit candidate entry with confirm/offer handshake to a downstream tally.
// Optional inactivity auto-clear of ENTRY is enabled by VOTE_ENTRY_TIMEOUT_EN.
module vote_entry
   import urna_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key0,
   input  logic       key1,
   input  logic       key2,
   input  logic       chave,
   input  logic       vote_ready,
   output logic       vote_valid,
   output logic [2:0] cand_id,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic       busy
);

   localparam int NUM_KEYS = 3;

   logic [NUM_KEYS-1:0] raw;
   logic [NUM_KEYS-1:0] lvl;
   logic [NUM_KEYS-1:0] press;
   logic                unused_lvl;
   vote_state_e         state;

   assign raw        = {key2, key1, key0};
   assign unused_lvl = ^lvl[NUM_KEYS-1:1];

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clock (clock),
         .reset (reset),
         .key   (raw[gi]),
         .level (lvl[gi]),
         .press (press[gi])
      );
   end

`ifdef VOTE_ENTRY_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         bcd1       <= 4'd0;
         bcd2       <= 4'd0;
         cand_id    <= CAND_NULL;
         vote_valid <= 1'b0;
         busy       <= 1'b0;
`ifdef VOTE_ENTRY_TIMEOUT_EN
         tmr        <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_ENTRY: begin
`ifdef VOTE_ENTRY_TIMEOUT_EN
               if (|press) begin
                  tmr <= '0;
               end else if (state == ST_ENTRY) begin
                  if (tmr == TMR_LAST) begin
                     bcd1  <= 4'd0;
                     bcd2  <= 4'd0;
                     state <= ST_IDLE;
                     tmr   <= '0;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
`endif
               // A live confirm swallows any digit press of the same cycle.
               if (!chave && state == ST_ENTRY && press[0]) begin
                  cand_id    <= cand_of(bcd1, bcd2);
                  vote_valid <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_OFFER;
               end else if (!chave && (press[1] || press[2])) begin
                  if (press[1]) bcd1 <= bcd_inc(bcd1);
                  if (press[2]) bcd2 <= bcd_inc(bcd2);
                  state <= ST_ENTRY;
               end
            end
            ST_OFFER: begin
               if (vote_ready) begin
                  vote_valid <= 1'b0;
                  bcd1       <= 4'd0;
                  bcd2       <= 4'd0;
                  if (lvl[0]) begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               if (lvl[0]) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign hex1 = seg7(bcd1);
   assign hex2 = seg7(bcd2);

endmodule

// File: tb/tb_vote_entry.sv
// Directed bench for vote_entry with short debounce; timeout checks run when
// VOTE_ENTRY_TIMEOUT_EN is defined.
module tb_vote_entry;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key0 = 1'b1, key1 = 1'b1, key2 = 1'b1;
   logic       chave = 1'b0;
   logic       vote_ready = 1'b0;
   logic       vote_valid;
   logic [2:0] cand_id;
   logic [3:0] bcd1, bcd2;
   logic [6:0] hex1, hex2;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int vv_cnt = 0;

   vote_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
      .clock      (clock),
      .reset      (reset),
      .key0       (key0),
      .key1       (key1),
      .key2       (key2),
      .chave      (chave),
      .vote_ready (vote_ready),
      .vote_valid (vote_valid),
      .cand_id    (cand_id),
      .bcd1       (bcd1),
      .bcd2       (bcd2),
      .hex1       (hex1),
      .hex2       (hex2),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (vote_valid) vv_cnt <= vv_cnt + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key0 = v;
         1: key1 = v;
         default: key2 = v;
      endcase
   endtask

   task automatic press_key(input int k);
      set_key(k, 1'b0);
      cyc(10);
      set_key(k, 1'b1);
      cyc(10);
   endtask

   task automatic wait_valid(input int lim, output bit ok);
      int n = 0;
      while (!vote_valid && n < lim) begin
         cyc(1);
         n++;
      end
      ok = vote_valid;
   endtask

   initial begin
      bit ok;
      int v0, nv, good, n;
      logic [2:0] seen_cand;

      cyc(3);
      chk("rst_valid", vote_valid, 0);
      chk("rst_cand", cand_id, 4);
      chk("rst_bcd", {bcd1, bcd2}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_hex1", hex1, 7'b1000000);
      reset = 1'b1;
      cyc(3);

      // key2 bounces three times then settles low: one increment only
      for (int i = 0; i < 3; i++) begin
         key2 = 1'b0; cyc(1);
         key2 = 1'b1; cyc(1);
      end
      key2 = 1'b0; cyc(10);
      key2 = 1'b1; cyc(10);
      chk("bounce_bcd2", bcd2, 1);
      chk("bounce_bcd1", bcd1, 0);

      // 0/1 -> 1/3, confirm with ready high: one-cycle offer of candidate 13
      press_key(1);
      press_key(2);
      press_key(2);
      chk("entry_13", {bcd1, bcd2}, 8'h13);
      chk("hex2_3", hex2, 7'b0110000);
      vote_ready = 1'b1;
      v0 = vv_cnt;
      seen_cand = 3'd7;
      key0 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (vote_valid) seen_cand = cand_id;
      end
      chk("offer_cycles", vv_cnt - v0, 1);
      chk("offer_cand", seen_cand, 1);
      chk("post_hs_bcd", {bcd1, bcd2}, 0);
      chk("busy_hold", busy, 1);
      press_key(1);
      chk("release_ignore", bcd1, 0);
      key0 = 1'b1;
      cyc(12);
      chk("busy_clear", busy, 0);
      vote_ready = 1'b0;

      // 9/9 then simultaneous increment wraps both digits
      for (int i = 0; i < 9; i++) press_key(1);
      for (int i = 0; i < 9; i++) press_key(2);
      chk("nine_nine", {bcd1, bcd2}, 8'h99);
      chk("hex1_9", hex1, 7'b0010000);
      key1 = 1'b0; key2 = 1'b0;
      cyc(10);
      key1 = 1'b1; key2 = 1'b1;
      cyc(10);
      chk("wrap_bcd", {bcd1, bcd2}, 0);
      chk("wrap_hex1", hex1, 7'b1000000);
      chk("wrap_hex2", hex2, 7'b1000000);

      // 4/4 null vote held with ready low; digit presses ignored during offer
      for (int i = 0; i < 4; i++) press_key(1);
      for (int i = 0; i < 4; i++) press_key(2);
      key0 = 1'b0;
      wait_valid(20, ok);
      chk("null_offer", ok, 1);
      key1 = 1'b0; key2 = 1'b0;
      good = 0;
      for (int i = 0; i < 10; i++) begin
         if (vote_valid && cand_id == 3'd4) good++;
         cyc(1);
      end
      key1 = 1'b1; key2 = 1'b1;
      cyc(8);
      chk("null_stable", good, 10);
      chk("null_still", vote_valid, 1);
      chk("offer_ignore", {bcd1, bcd2}, 8'h44);
      vote_ready = 1'b1;
      cyc(1);
      vote_ready = 1'b0;
      chk("null_hs_valid", vote_valid, 0);
      chk("null_hs_bcd", {bcd1, bcd2}, 0);
      key0 = 1'b1;
      cyc(12);

      // count mode locks entry and confirm
      press_key(1);
      chave = 1'b1;
      v0 = vv_cnt;
      press_key(1);
      press_key(2);
      press_key(0);
      nv = vv_cnt - v0;
      chk("chave_bcd", {bcd1, bcd2}, 8'h10);
      chk("chave_novalid", nv, 0);
      chave = 1'b0;

      // asynchronous reset in the middle of an offer
      key0 = 1'b0;
      wait_valid(20, ok);
      chk("pre_rst_valid", ok, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", vote_valid, 0);
      chk("mid_rst_cand", cand_id, 4);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_bcd", {bcd1, bcd2}, 0);
      key0 = 1'b1;
      cyc(2);
      reset = 1'b1;
      cyc(12);
      chk("post_rst_valid", vote_valid, 0);

`ifdef VOTE_ENTRY_TIMEOUT_EN
      key1 = 1'b0;
      n = 0;
      while (bcd1 != 4'd1 && n < 20) begin
         cyc(1);
         n++;
      end
      chk("to_entry", bcd1, 1);
      n = 0;
      while (bcd1 != 4'd0 && n < 40) begin
         cyc(1);
         n++;
      end
      chk("to_cycles", n, 20);
      key1 = 1'b1;
      cyc(10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
